// File: rtl/pwm_duty_meter.sv
// Per-channel PWM duty meter: counts synchronized high cycles over a 2^WIDTH-cycle
// enabled window and latches a saturated duty value per channel at each window end.
module pwm_duty_meter #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 8,
   localparam int SELW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [SIZE-1:0]   pwm_in,
   input  logic [SELW-1:0]   sel,
   output logic [WIDTH-1:0]  duty_out,
   output logic              window_done,
   output logic              valid,
   output logic [SIZE-1:0]   changed
);

   localparam int AW = WIDTH + 1;

   logic [SIZE-1:0]  s1_q, s2_q;
   logic [WIDTH-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0]    acc_q [SIZE];
   logic [AW-1:0]    acc_d [SIZE];
   logic [AW-1:0]    total_w [SIZE];
   logic [WIDTH-1:0] sat_w [SIZE];
   logic [WIDTH-1:0] res_q [SIZE];
   logic [WIDTH-1:0] res_d [SIZE];
   logic [SIZE-1:0]  changed_q, changed_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             last_w;

   always_comb begin
      last_w    = en && (wcnt_q == '1);
      wcnt_d    = en ? wcnt_q + 1'b1 : wcnt_q;
      done_d    = last_w;
      valid_d   = valid_q | last_w;
      changed_d = changed_q;
      for (int unsigned i = 0; i < SIZE; i++) begin
         total_w[i] = acc_q[i] + AW'(s2_q[i]);
         // A channel high for the full window would wrap to 0; clamp to full scale instead.
         sat_w[i]   = total_w[i][WIDTH] ? '1 : total_w[i][WIDTH-1:0];
         acc_d[i]   = acc_q[i];
         res_d[i]   = res_q[i];
         if (last_w) begin
            acc_d[i]     = '0;
            res_d[i]     = sat_w[i];
            changed_d[i] = (sat_w[i] != res_q[i]);
         end else if (en) begin
            acc_d[i] = total_w[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         wcnt_q    <= '0;
         changed_q <= '0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         for (int unsigned i = 0; i < SIZE; i++) begin
            acc_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         s1_q      <= pwm_in;
         s2_q      <= s1_q;
         wcnt_q    <= wcnt_d;
         changed_q <= changed_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         for (int unsigned i = 0; i < SIZE; i++) begin
            acc_q[i] <= acc_d[i];
            res_q[i] <= res_d[i];
         end
      end
   end

   // Pad the result table to the full select range so out-of-range selects read 0.
   logic [WIDTH-1:0] res_pad [2**SELW];

   for (genvar k = 0; k < 2**SELW; k++) begin : g_pad
      if (k < SIZE) begin : g_ch
         assign res_pad[k] = res_q[k];
      end else begin : g_zero
         assign res_pad[k] = '0;
      end
   end

   assign duty_out    = res_pad[sel];
   assign window_done = done_q;
   assign valid       = valid_q;
   assign changed     = changed_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter, checked against a window-queue reference model.
module tb_pwm_duty_meter;

   localparam int W   = 8;
   localparam int N   = 8;
   localparam int SW  = 3;
   localparam int WIN = 1 << W;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [N-1:0]  pwm_in;
   logic [SW-1:0] sel;
   logic [W-1:0]  duty_out;
   logic          window_done;
   logic          valid;
   logic [N-1:0]  changed;

   pwm_duty_meter #(.WIDTH(W), .SIZE(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .pwm_in      (pwm_in),
      .sel         (sel),
      .duty_out    (duty_out),
      .window_done (window_done),
      .valid       (valid),
      .changed     (changed)
   );

   always #20 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: input reaches the counted sample 2 edges late; a window is the
   // list of the last 2^W enabled samples, duty = min(count of highs, 2^W-1).
   logic [N-1:0] s1m, s2m;
   logic [N-1:0] win_q[$];
   int           resm [N];
   logic [N-1:0] chm;
   bit           donem, validm;

   task automatic model_step();
      if (rst) begin
         s1m = '0; s2m = '0;
         win_q.delete();
         foreach (resm[c]) resm[c] = 0;
         chm = '0; donem = 0; validm = 0;
      end else begin
         donem = 0;
         if (en) begin
            win_q.push_back(s2m);
            if (win_q.size() == WIN) begin
               for (int c = 0; c < N; c++) begin
                  int cnt, r;
                  cnt = 0;
                  foreach (win_q[k]) cnt += int'(win_q[k][c]);
                  r = (cnt > WIN - 1) ? WIN - 1 : cnt;
                  chm[c]  = (r != resm[c]);
                  resm[c] = r;
               end
               donem  = 1;
               validm = 1;
               win_q.delete();
            end
         end
         s2m = s1m;
         s1m = pwm_in;
      end
   endtask

   task automatic cycle(input bit r, input bit e, input logic [N-1:0] p);
      @(negedge clk);
      rst = r; en = e; pwm_in = p;
      sel = SW'($urandom_range(0, N - 1));
      @(posedge clk);
      model_step();
      #1;
      check("window_done", window_done, donem);
      check("valid", valid, validm);
      check("changed", changed, chm);
      if (donem) begin
         for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            #1;
            check($sformatf("duty_out[%0d]", s), duty_out, resm[s]);
         end
      end else begin
         check("duty_out", duty_out, resm[sel]);
      end
   endtask

   // Runs enabled cycles with constant input until a done pulse; n = cycles taken or -1.
   task automatic run_to_done(input logic [N-1:0] p, input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         cycle(0, 1, p);
         if (window_done) begin
            n = i;
            break;
         end
      end
   endtask

   logic [W-1:0] duty [N];
   logic [W-1:0] pc;

   task automatic gen_cycles(input int n);
      logic [N-1:0] p;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < N; c++) p[c] = (pc < duty[c]);
         pc++;
         cycle(0, 1, p);
      end
   endtask

   initial begin
      int  n;
      bit  seen;
      rst = 1'b1; en = 1'b0; pwm_in = '0; sel = '0; pc = '0;

      // All channels low; first pulse 256 cycles after release.
      repeat (3) cycle(1, 0, '0);
      seen = 0;
      for (int i = 1; i <= 300; i++) begin
         cycle(0, 1, '0);
         if (window_done && !seen) begin
            seen = 1;
            check("first_done_latency", i, WIN);
         end
      end
      check("first_done_seen", seen, 1);

      // Saturation from reset: 254, then 255, then stable.
      repeat (2) cycle(1, 1, 8'hFF);
      for (int w = 0; w < 3; w++) run_to_done(8'hFF, 2 * WIN, n);
      sel = 3'd2; #1;
      check("sat_steady", duty_out, WIN - 1);
      check("sat_changed", changed, 0);

      // Generator-like duties.
      foreach (duty[c]) duty[c] = W'($urandom);
      duty[0] = 8'h40; duty[3] = 8'hC0;
      gen_cycles(4 * WIN);
      run_to_done('0, 2 * WIN, n);
      gen_cycles(3 * WIN);
      sel = 3'd0; #1;
      check("gen_ch0", duty_out, 64);
      sel = 3'd3; #1;
      check("gen_ch3", duty_out, 192);

      // Enable pause of 100 cycles delays the pulse by exactly 100.
      run_to_done(8'h01, 2 * WIN, n);
      run_to_done(8'h01, 2 * WIN, n);
      repeat (50) cycle(0, 1, 8'h01);
      repeat (100) cycle(0, 0, 8'h01);
      run_to_done(8'h01, 2 * WIN, n);
      check("pause_gap", n + 150, WIN + 100);
      run_to_done(8'h01, 2 * WIN, n);
      sel = 3'd0; #1;
      check("pause_ch0", duty_out, WIN - 1);

      // Reset mid-window at wcnt=128.
      repeat (128) cycle(0, 1, 8'h5A);
      cycle(1, 1, 8'h5A);
      check("rst_duty", duty_out, 0);
      run_to_done(8'h5A, 2 * WIN, n);
      check("rst_done_gap", n, WIN);

      // Channel 5 switch from 1 to 0.
      for (int w = 0; w < 2; w++) run_to_done(8'h20, 2 * WIN, n);
      for (int w = 0; w < 3; w++) run_to_done(8'h00, 2 * WIN, n);
      sel = 3'd5; #1;
      check("ch5_settled", duty_out, 0);
      check("ch5_changed", changed, 0);

      // Random traffic with enable gaps and rare resets.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 85, N'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
